// File: rtl/arb_out_fifo_pkg.sv
`default_nettype none
// ============================================================================
// arb_out_fifo_pkg : shared widths for the arbiter output FIFO
// Rev 1.0
// ============================================================================
package arb_out_fifo_pkg;
  // Payload width shared with the round-robin arbiter.
  localparam int unsigned c_DATA_SIZE = 32;
endpackage
`default_nettype wire

// File: rtl/arb_out_fifo_mem.sv
`default_nettype none
// ============================================================================
// arb_out_fifo_mem : register array, one sync write port, one async read port
// Rev 1.0
// ============================================================================
module arb_out_fifo_mem #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [DATA_SIZE-1:0] o_rdata
);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  // Reset clears every entry so the head reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/arb_out_fifo.sv
`default_nettype none
// ============================================================================
// arb_out_fifo : valid/ready FIFO between the arbiter and the shared consumer
// Rev 1.0
// ============================================================================
module arb_out_fifo
  import arb_out_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATA_SIZE = c_DATA_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       src_valid_i,
  output logic                       src_ready_o,
  input  logic [DATA_SIZE-1:0]       src_data_i,
  output logic                       dst_valid_o,
  input  logic                       dst_ready_i,
  output logic [DATA_SIZE-1:0]       dst_data_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_pop;

  // Extra MSB is the wrap bit: equal index with differing wrap means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                   (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

  assign src_ready_o = !w_full;
  assign dst_valid_o = !w_empty;
  assign w_push      = src_valid_i && src_ready_o;
  assign w_pop       = dst_valid_o && dst_ready_i;
  assign cnt_o       = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  arb_out_fifo_mem #(
    .DEPTH     (DEPTH),
    .DATA_SIZE (DATA_SIZE),
    .AW        (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[PTR_W-1:0]),
    .i_wdata (src_data_i),
    .i_raddr (r_rd_ptr[PTR_W-1:0]),
    .o_rdata (dst_data_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_arb_out_fifo.sv
`default_nettype none
// ============================================================================
// tb_arb_out_fifo : directed self-checking bench for arb_out_fifo (DEPTH=4)
// Rev 1.0
// ============================================================================
module tb_arb_out_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_valid_i;
  logic        src_ready_o;
  logic [31:0] src_data_i;
  logic        dst_valid_o;
  logic        dst_ready_i;
  logic [31:0] dst_data_o;
  logic [2:0]  cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_out_fifo #(.DEPTH(4), .DATA_SIZE(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .src_data_i  (src_data_i),
    .dst_valid_o (dst_valid_o),
    .dst_ready_i (dst_ready_i),
    .dst_data_o  (dst_data_o),
    .cnt_o       (cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int next_in;
    int next_out;
    logic w_push;
    logic w_pop;

    rst_n       = 1'b0;
    src_valid_i = 1'b0;
    src_data_i  = 32'hDEAD_BEEF;
    dst_ready_i = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset then idle
    chk("rst_ready", 32'(src_ready_o), 1);
    chk("rst_valid", 32'(dst_valid_o), 0);
    chk("rst_cnt",   32'(cnt_o), 0);
    chk("rst_data",  dst_data_o, 0);
    tick();
    chk("idle_cnt",  32'(cnt_o), 0);

    // Single pass
    src_valid_i = 1'b1;
    src_data_i  = 32'hA5A5_0001;
    tick();
    src_valid_i = 1'b0;
    src_data_i  = 32'h1234_5678;
    chk("sp_valid", 32'(dst_valid_o), 1);
    chk("sp_data",  dst_data_o, 32'hA5A5_0001);
    chk("sp_cnt",   32'(cnt_o), 1);
    dst_ready_i = 1'b1;
    tick();
    dst_ready_i = 1'b0;
    chk("sp_empty", 32'(dst_valid_o), 0);
    chk("sp_cnt0",  32'(cnt_o), 0);

    // Fill and stall
    for (int i = 1; i <= 4; i++) begin
      src_valid_i = 1'b1;
      src_data_i  = 32'(i);
      tick();
    end
    chk("fill_cnt",   32'(cnt_o), 4);
    chk("fill_ready", 32'(src_ready_o), 0);
    src_data_i = 32'd5;
    tick();
    chk("full_hold_cnt",  32'(cnt_o), 4);
    chk("full_hold_head", dst_data_o, 1);
    dst_ready_i = 1'b1;
    tick();
    chk("full_pop_cnt",   32'(cnt_o), 3);
    chk("full_pop_head",  dst_data_o, 2);
    chk("full_pop_ready", 32'(src_ready_o), 1);
    dst_ready_i = 1'b0;
    tick();
    src_valid_i = 1'b0;
    chk("fifth_cnt", 32'(cnt_o), 4);
    dst_ready_i = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("drain_head", dst_data_o, 32'(i));
      tick();
    end
    dst_ready_i = 1'b0;
    chk("drain_cnt",   32'(cnt_o), 0);
    chk("drain_valid", 32'(dst_valid_o), 0);

    // Simultaneous push/pop at occupancy 2
    src_valid_i = 1'b1;
    src_data_i  = 32'd10;
    tick();
    src_data_i  = 32'd11;
    tick();
    chk("pp_start_cnt", 32'(cnt_o), 2);
    dst_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      src_data_i = 32'(12 + k);
      chk("pp_head", dst_data_o, 32'(10 + k));
      tick();
      chk("pp_cnt", 32'(cnt_o), 2);
    end
    src_valid_i = 1'b0;
    chk("pp_tail0", dst_data_o, 32'd20);
    tick();
    chk("pp_tail1", dst_data_o, 32'd21);
    tick();
    dst_ready_i = 1'b0;
    chk("pp_empty", 32'(dst_valid_o), 0);

    // Wrap-around with random handshakes
    next_in  = 0;
    next_out = 0;
    for (int cyc = 0; cyc < 600 && next_out < 20; cyc++) begin
      src_valid_i = (next_in < 20) && ($urandom_range(1) == 1);
      src_data_i  = 32'(next_in);
      dst_ready_i = ($urandom_range(1) == 1);
      w_push = src_valid_i && src_ready_o;
      w_pop  = dst_valid_o && dst_ready_i;
      if (w_pop) begin
        chk("wrap_data", dst_data_o, 32'(next_out));
        next_out++;
      end
      if (w_push) next_in++;
      tick();
      chk("wrap_cnt", 32'(cnt_o), 32'(next_in - next_out));
      chk("wrap_le4", 32'(cnt_o <= 3'd4), 1);
    end
    src_valid_i = 1'b0;
    dst_ready_i = 1'b0;
    chk("wrap_done", 32'(next_out), 20);

    // Mid-operation reset
    src_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_data_i = 32'(100 + i);
      tick();
    end
    src_valid_i = 1'b0;
    chk("mr_pre_cnt", 32'(cnt_o), 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_cnt",   32'(cnt_o), 0);
    chk("mr_valid", 32'(dst_valid_o), 0);
    chk("mr_ready", 32'(src_ready_o), 1);
    src_valid_i = 1'b1;
    src_data_i  = 32'h77;
    tick();
    src_valid_i = 1'b0;
    chk("mr_first", dst_data_o, 32'h77);
    chk("mr_cnt1",  32'(cnt_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
